// File: rtl/uart_cfg_pkg.sv
// Shared types, defaults and helpers for the runtime-configurable UART.
// UART_CFG_PARITY_EN adds the PARITY states to both engines.
package uart_cfg_pkg;

    localparam int DBIT_DEF     = 8;
    localparam int DVSR_BIT_DEF = 11;
    localparam int FIFO_W_DEF   = 4;
    localparam int OVS_DEF      = 16;
    // RX words carry the widest supported data field so one struct fits every DBIT
    localparam int DBIT_MAX     = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_CFG_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_CFG_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef struct packed {
        logic                ferr;
        logic                perr;
        logic [DBIT_MAX-1:0] data;
    } rx_word_t;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// Synchronous show-ahead FIFO with registered pointers and flags; the head
// reads as zero while empty.
module uart_cfg_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    w_ptr, r_ptr, w_nxt, r_nxt;
    logic             wr_en, rd_en;

    // A write into a full FIFO still lands when the same cycle frees a slot
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;
    assign w_nxt = w_ptr + 1'b1;
    assign r_nxt = r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    w_ptr <= w_nxt;
                    empty <= 1'b0;
                    full  <= (w_nxt == r_ptr);
                end
                2'b01: begin
                    r_ptr <= r_nxt;
                    full  <= 1'b0;
                    empty <= (r_nxt == w_ptr);
                end
                2'b11: begin
                    w_ptr <= w_nxt;
                    r_ptr <= r_nxt;
                end
                default: ;
            endcase
        end
    end

    assign r_data = empty ? '0 : mem[r_ptr];

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud generator, RX/TX engines and two FIFOs.
// Define UART_CFG_PARITY_EN to send/check a parity bit selected by par_mode.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int DVSR_BIT = DVSR_BIT_DEF,
    parameter int FIFO_W   = FIFO_W_DEF,
    parameter int OVS      = OVS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                stop2,
    input  logic [1:0]          par_mode,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                rd_uart,
    input  logic                clr_ovr,
    input  logic                rx,
    output logic                tx,
    output logic                tx_full,
    output logic                tx_idle,
    output logic                rx_empty,
    output logic [DBIT-1:0]     r_data,
    output logic                r_perr,
    output logic                r_ferr,
    output logic                ovr_err
);

    localparam int SW = $clog2(2 * OVS);
    localparam int NW = $clog2(DBIT + 1);
    localparam int RXW = $bits(rx_word_t);
    localparam logic [SW-1:0] HALF_M1  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_M1   = SW'(OVS - 1);
    localparam logic [SW-1:0] BIT_M2   = SW'(OVS - 2);
    localparam logic [SW-1:0] STOP2_M1 = SW'(2 * OVS - 1);
    localparam logic [SW-1:0] STOP2_M2 = SW'(2 * OVS - 2);
    localparam logic [NW-1:0] DBIT_LAST = NW'(DBIT - 1);

    logic [DVSR_BIT-1:0] baud_cnt, dvsr_q;
    logic                tick;

    // Divisor is re-latched only at the wrap so a running period is never cut short
    assign tick = (baud_cnt == dvsr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            dvsr_q   <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
            dvsr_q   <= dvsr;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    logic rx_m, rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_state_e       rx_state;
    logic [SW-1:0]   rx_tcnt;
    logic [NW-1:0]   rx_ncnt;
    logic [DBIT-1:0] rx_shift;
    logic            rx_stop2, rx_ferr, rx_push, rx_bit_smp, rx_full;
    rx_word_t        rx_word, rx_head;
    logic            rx_head_unused;
`ifdef UART_CFG_PARITY_EN
    logic            rx_par_en, rx_odd, rx_perr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_ncnt  <= '0;
            rx_stop2 <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_push  <= 1'b0;
`ifdef UART_CFG_PARITY_EN
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            rx_perr   <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: if (!rx_s) begin
                    rx_state <= RX_START;
                    rx_tcnt  <= '0;
                    rx_stop2 <= stop2;
                    rx_ferr  <= 1'b0;
`ifdef UART_CFG_PARITY_EN
                    rx_par_en <= par_enabled(par_mode);
                    rx_odd    <= (par_mode == PAR_ODD);
                    rx_perr   <= 1'b0;
`endif
                end
                RX_START: if (tick) begin
                    if (rx_tcnt == HALF_M1) begin
                        rx_tcnt  <= '0;
                        rx_ncnt  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
                RX_DATA: if (tick) begin
                    if (rx_tcnt == BIT_M1) begin
                        rx_tcnt <= '0;
                        rx_ncnt <= rx_ncnt + 1'b1;
                        if (rx_ncnt == DBIT_LAST) begin
`ifdef UART_CFG_PARITY_EN
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
`ifdef UART_CFG_PARITY_EN
                RX_PARITY: if (tick) begin
                    if (rx_tcnt == BIT_M1) begin
                        rx_tcnt  <= '0;
                        rx_perr  <= (^rx_shift) ^ rx_s ^ rx_odd;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
`endif
                RX_STOP: if (tick) begin
                    if (rx_tcnt == BIT_M1) rx_ferr <= !rx_s;
                    if (rx_tcnt == (rx_stop2 ? STOP2_M1 : BIT_M1)) begin
                        rx_push  <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_tcnt <= rx_tcnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_bit_smp = tick && (rx_state == RX_DATA) && (rx_tcnt == BIT_M1);

    always_ff @(posedge clk) begin
        if (rx_bit_smp) rx_shift <= {rx_s, rx_shift[DBIT-1:1]};
    end

    always_comb begin
        rx_word                 = '0;
        rx_word.ferr            = rx_ferr;
`ifdef UART_CFG_PARITY_EN
        rx_word.perr            = rx_perr;
`endif
        rx_word.data[DBIT-1:0]  = rx_shift;
    end

    uart_cfg_fifo #(.WIDTH(RXW), .AW(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (rx_push),
        .rd     (rd_uart),
        .w_data (rx_word),
        .r_data (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    // A push that coincides with a pop is accepted, so only that case escapes the overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_err <= 1'b0;
        end else if (rx_push && rx_full && !rd_uart) begin
            ovr_err <= 1'b1;
        end else if (clr_ovr) begin
            ovr_err <= 1'b0;
        end
    end

    assign r_data         = rx_head.data[DBIT-1:0];
    assign r_ferr         = rx_head.ferr;
    assign rx_head_unused = ^rx_head;
`ifdef UART_CFG_PARITY_EN
    assign r_perr = rx_head.perr;
`else
    logic par_mode_unused;
    assign par_mode_unused = ^par_mode;
    assign r_perr = 1'b0;
`endif

    tx_state_e       tx_state;
    logic [SW-1:0]   tx_tcnt;
    logic [NW-1:0]   tx_ncnt;
    logic [DBIT-1:0] tx_shift, tx_head;
    logic            tx_stop2, tx_reg, tx_pop, tx_empty, tx_bit_adv;
`ifdef UART_CFG_PARITY_EN
    logic            tx_par_en, tx_par_bit;
`endif

    assign tx_pop     = (tx_state == TX_IDLE) && tick && !tx_empty;
    assign tx_bit_adv = tick && (tx_state == TX_DATA) && (tx_tcnt == BIT_M1);

    uart_cfg_fifo #(.WIDTH(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr_uart),
        .rd     (tx_pop),
        .w_data (w_data),
        .r_data (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (tx_pop) tx_shift <= tx_head;
        else if (tx_bit_adv) tx_shift <= tx_shift >> 1;
    end

    // STOP hands over one tick early; the final stop tick is spent in IDLE so
    // a queued word starts right after the stop period with no extra gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_ncnt  <= '0;
            tx_stop2 <= 1'b0;
            tx_reg   <= 1'b1;
`ifdef UART_CFG_PARITY_EN
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_pop) begin
                    tx_state <= TX_START;
                    tx_tcnt  <= '0;
                    tx_reg   <= 1'b0;
                    tx_stop2 <= stop2;
`ifdef UART_CFG_PARITY_EN
                    tx_par_en  <= par_enabled(par_mode);
                    tx_par_bit <= (^tx_head) ^ (par_mode == PAR_ODD);
`endif
                end
                TX_START: if (tick) begin
                    if (tx_tcnt == BIT_M1) begin
                        tx_tcnt  <= '0;
                        tx_ncnt  <= '0;
                        tx_reg   <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                    end
                end
                TX_DATA: if (tick) begin
                    if (tx_tcnt == BIT_M1) begin
                        tx_tcnt <= '0;
                        tx_ncnt <= tx_ncnt + 1'b1;
                        if (tx_ncnt == DBIT_LAST) begin
`ifdef UART_CFG_PARITY_EN
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                            tx_reg   <= tx_par_en ? tx_par_bit : 1'b1;
`else
                            tx_state <= TX_STOP;
                            tx_reg   <= 1'b1;
`endif
                        end else begin
                            tx_reg <= tx_shift[1];
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                    end
                end
`ifdef UART_CFG_PARITY_EN
                TX_PARITY: if (tick) begin
                    if (tx_tcnt == BIT_M1) begin
                        tx_tcnt  <= '0;
                        tx_reg   <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                    end
                end
`endif
                TX_STOP: if (tick) begin
                    if (tx_tcnt == (tx_stop2 ? STOP2_M2 : BIT_M2)) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_tcnt <= tx_tcnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_reg;
    assign tx_idle = tx_empty && (tx_state == TX_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: TX framing, loopback, parity/framing errors,
// overrun, divisor and asynchronous reset behaviour.
module tb_uart_cfg;

    localparam int DBIT     = 8;
    localparam int DVSR_BIT = 11;
    localparam int OVS      = 16;
`ifdef UART_CFG_PARITY_EN
    localparam logic PAR_HW = 1'b1;
`else
    localparam logic PAR_HW = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DVSR_BIT-1:0] dvsr = '0;
    logic                stop2 = 1'b0;
    logic [1:0]          par_mode = 2'b00;
    logic                wr_uart = 1'b0;
    logic [DBIT-1:0]     w_data = '0;
    logic                rd_uart = 1'b0;
    logic                clr_ovr = 1'b0;
    logic                rx_drv = 1'b1;
    logic                loop = 1'b0;
    logic                rx;
    logic                tx, tx_full, tx_idle, rx_empty, r_perr, r_ferr, ovr_err;
    logic [DBIT-1:0]     r_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rx = loop ? tx : rx_drv;

    uart_cfg dut (
        .clk      (clk),
        .rst      (rst),
        .dvsr     (dvsr),
        .stop2    (stop2),
        .par_mode (par_mode),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .rd_uart  (rd_uart),
        .clr_ovr  (clr_ovr),
        .rx       (rx),
        .tx       (tx),
        .tx_full  (tx_full),
        .tx_idle  (tx_idle),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .r_perr   (r_perr),
        .r_ferr   (r_ferr),
        .ovr_err  (ovr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DBIT-1:0] d);
        w_data  = d;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pop();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int bound);
        int k = 0;
        while (rx_empty && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, rx_empty, 0);
    endtask

    task automatic wait_tx_low(input string tag);
        int k = 0;
        while (tx !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, tx, 0);
    endtask

    task automatic low_width(output int cnt);
        cnt = 0;
        while (tx === 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic pbit, input logic stop_low);
        rx_drv = 1'b0;
        cyc(OVS);
        for (int j = 0; j < DBIT; j++) begin
            rx_drv = d[j];
            cyc(OVS);
        end
        if (with_par) begin
            rx_drv = pbit;
            cyc(OVS);
        end
        if (stop_low) begin
            rx_drv = 1'b0;
            cyc(10);
        end
        rx_drv = 1'b1;
        cyc(2 * OVS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] lb [3];
        int         w;
        int         k;

        // reset state, checked while reset is held
        cyc(3);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_perr", r_perr, 0);
        chk("rst_r_ferr", r_ferr, 0);
        chk("rst_ovr_err", ovr_err, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        // 8N1 frame of 0xA5 at one tick per clock
        v = 8'hA5;
        push(v);
        wait_tx_low("a5_start_seen");
        low_width(w);
        chk("a5_start_width", w, OVS);
        cyc(OVS / 2);
        for (int j = 0; j < DBIT; j++) begin
            chk($sformatf("a5_bit%0d", j), tx, v[j]);
            cyc(OVS);
        end
        chk("a5_stop", tx, 1);
        cyc(OVS);
        chk("a5_tx_idle", tx_idle, 1);
        chk("a5_tx_high", tx, 1);

        // loopback, even parity, two stop bits
        par_mode = 2'b01;
        stop2    = 1'b1;
        loop     = 1'b1;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h3C;
        for (int i = 0; i < 3; i++) push(lb[i]);
        for (int i = 0; i < 3; i++) begin
            wait_rx($sformatf("lb%0d_arrive", i), 1000);
            chk($sformatf("lb%0d_data", i), r_data, lb[i]);
            chk($sformatf("lb%0d_perr", i), r_perr, 0);
            chk($sformatf("lb%0d_ferr", i), r_ferr, 0);
            pop();
        end
        chk("lb_drained", rx_empty, 1);
        cyc(3 * OVS);
        loop  = 1'b0;
        stop2 = 1'b0;
        cyc(4);

        // odd parity selected, wrong parity bit on 0x01
        par_mode = 2'b10;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        wait_rx("perr_arrive", 200);
        chk("perr_data", r_data, 8'h01);
        chk("perr_flag", r_perr, PAR_HW);
        chk("perr_ferr", r_ferr, 0);
        pop();

        // stop bit held low on 0x55, then a short glitch
        par_mode = 2'b00;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        wait_rx("ferr_arrive", 200);
        chk("ferr_data", r_data, 8'h55);
        chk("ferr_flag", r_ferr, 1);
        chk("ferr_perr", r_perr, 0);
        pop();
        cyc(40);
        chk("ferr_no_extra_word", rx_empty, 1);
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(60);
        chk("glitch_no_word", rx_empty, 1);

        // 17 words with no reads: 16 kept, one dropped
        loop = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("ovr_tx_full", tx_full, 1);
        k = 0;
        while (!tx_idle && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("ovr_tx_done", tx_idle, 1);
        cyc(40);
        chk("ovr_flag_set", ovr_err, 1);
        chk("ovr_rx_not_empty", rx_empty, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr_word%0d", i), r_data, i);
            pop();
        end
        chk("ovr_drained", rx_empty, 1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_cleared", ovr_err, 0);
        loop = 1'b0;

        // divisor 1 doubles the bit time; reset lands mid-frame
        dvsr = 11'd1;
        push(8'h33);
        wait_tx_low("dv1_start_seen");
        low_width(w);
        chk("dv1_start_width", w, 2 * OVS);
        cyc(4 * OVS + 6);
        chk("dv1_bit2_low", tx, 0);
        rst = 1'b0;
        #1;
        chk("midrst_tx_high", tx, 1);
        @(negedge clk);
        rst  = 1'b1;
        dvsr = '0;
        cyc(2);
        chk("midrst_tx_idle", tx_idle, 1);
        chk("midrst_tx_full", tx_full, 0);
        chk("midrst_rx_empty", rx_empty, 1);
        cyc(3 * OVS);
        chk("midrst_tx_stays_high", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
